// File: rtl/fifo_byte_to_word_if.sv
// Byte-in / word-out handshake bundle for fifo_byte_to_word.
// master = byte source and word consumer side, slave = the FIFO itself.
interface fifo_byte_to_word_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                    wr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    rd;
    logic [2*DATA_WIDTH-1:0] r_data;
    logic                    full;
    logic                    empty;
    logic [ADDR_WIDTH+1:0]   byte_count;
    logic                    err;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, byte_count, err
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, byte_count, err
    );
endinterface

// File: rtl/fifo_byte_to_word.sv
// Asymmetric FIFO: one byte per write, one show-ahead word {older, newer} per read.
// Define FIFO_BYTE_TO_WORD_ERR_EN to build the sticky protocol-error flag; otherwise err is 0.
module fifo_byte_to_word #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    fifo_byte_to_word_if.slave  bus
);
    localparam int ROWS = 1 << (ADDR_WIDTH + 1);
    localparam logic [ADDR_WIDTH+1:0] FULL_CNT = (ADDR_WIDTH + 2)'(ROWS);

    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr_pair;
    logic [ADDR_WIDTH+1:0] byte_count;
    logic [ADDR_WIDTH+1:0] count_inc;
    logic [ADDR_WIDTH+1:0] count_dec;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full        = (byte_count == FULL_CNT);
    assign empty       = (byte_count[ADDR_WIDTH+1:1] == '0);
    assign wr_acc      = bus.wr & ~full;
    assign rd_acc      = bus.rd & ~empty;
    assign rd_ptr_pair = rd_ptr + (ADDR_WIDTH + 1)'(1);

    // Count arithmetic stays at ADDR_WIDTH+2 bits; rd_acc implies count >= 2, so no underflow.
    assign count_inc = {{(ADDR_WIDTH + 1){1'b0}}, wr_acc};
    assign count_dec = {{ADDR_WIDTH{1'b0}}, rd_acc, 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            byte_count <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + (ADDR_WIDTH + 1)'(1);
            if (rd_acc) rd_ptr <= rd_ptr + (ADDR_WIDTH + 1)'(2);
            byte_count <= byte_count + count_inc - count_dec;
        end
    end

    // Storage rows carry no reset; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.w_data;
    end

    assign bus.r_data     = empty ? '0 : {mem[rd_ptr], mem[rd_ptr_pair]};
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.byte_count = byte_count;

`ifdef FIFO_BYTE_TO_WORD_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if ((bus.wr & full) | (bus.rd & empty)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_byte_to_word.sv
// Directed bench for fifo_byte_to_word (ADDR_WIDTH=3, DATA_WIDTH=8).
// Expected err follows FIFO_BYTE_TO_WORD_ERR_EN, so the same bench covers both builds.
module tb_fifo_byte_to_word;
`ifdef FIFO_BYTE_TO_WORD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    fifo_byte_to_word_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    fifo_byte_to_word #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive one cycle of stimulus, then sit 1 ns past the edge for sampling.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        bus.wr     = w;
        bus.w_data = d;
        bus.rd     = r;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_full",  32'(bus.full),       0);
        check("rst_empty", 32'(bus.empty),      1);
        check("rst_count", 32'(bus.byte_count), 0);
        check("rst_rdata", 32'(bus.r_data),     0);
        check("rst_err",   32'(bus.err),        0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b1;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.w_data = 8'h00;

        pulse_reset();

        // Packing two bytes into one word
        cyc(1'b1, 8'hA1, 1'b0);
        check("pack_cnt1",   32'(bus.byte_count), 1);
        check("pack_empty1", 32'(bus.empty),      1);
        check("pack_rdata1", 32'(bus.r_data),     0);
        cyc(1'b1, 8'hB2, 1'b0);
        check("pack_empty2", 32'(bus.empty),  0);
        check("pack_rdata2", 32'(bus.r_data), 32'h0000_A1B2);
        cyc(1'b0, 8'h00, 1'b1);
        check("pack_empty3", 32'(bus.empty),      1);
        check("pack_cnt3",   32'(bus.byte_count), 0);

        // Fill, overflow, drain (pointers start at row 2 here)
        for (int i = 0; i < 16; i++) begin
            check("fill_full_lo", 32'(bus.full), 0);
            cyc(1'b1, 8'(i), 1'b0);
        end
        check("fill_full",  32'(bus.full),       1);
        check("fill_cnt",   32'(bus.byte_count), 16);
        check("fill_err0",  32'(bus.err),        0);
        cyc(1'b1, 8'hFF, 1'b0);
        check("ovf_cnt",    32'(bus.byte_count), 16);
        check("ovf_err",    32'(bus.err),        32'(ERR_EN));
        for (int i = 0; i < 8; i++) begin
            check("drain_word", 32'(bus.r_data), 32'((2 * i) << 8 | (2 * i + 1)));
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("drain_empty", 32'(bus.empty),      1);
        check("drain_cnt",   32'(bus.byte_count), 0);

        // Wrap: data lands in rows 2..15 then 0..5
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        check("wrap_cnt", 32'(bus.byte_count), 12);
        check("wrap_w0",  32'(bus.r_data),     32'h0809);
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("wrap_word", 32'(bus.r_data), 32'((8'h20 + 2 * i) << 8 | (8'h21 + 2 * i)));
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("wrap_empty", 32'(bus.empty), 1);

        // Simultaneous write and read
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        check("sim_head", 32'(bus.r_data), 32'h1122);
        cyc(1'b1, 8'h44, 1'b1);
        check("sim_cnt",  32'(bus.byte_count), 2);
        check("sim_next", 32'(bus.r_data),     32'h3344);
        for (int i = 0; i < 14; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
        check("sim_full", 32'(bus.full), 1);
        cyc(1'b1, 8'hFF, 1'b1);
        check("simf_cnt",   32'(bus.byte_count), 14);
        check("simf_full",  32'(bus.full),       0);
        check("simf_rdata", 32'(bus.r_data),     32'h5051);
        for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1);
        check("simf_last", 32'(bus.byte_count), 0);
        check("simf_tail", 32'(bus.r_data),     0);

        // Sticky error and reset in the middle of traffic
        pulse_reset();
        cyc(1'b0, 8'h00, 1'b1);
        check("err_set",   32'(bus.err),        32'(ERR_EN));
        check("err_cnt",   32'(bus.byte_count), 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h61 + i), 1'b0);
        check("err_head",  32'(bus.r_data), 32'h6162);
        cyc(1'b0, 8'h00, 1'b1);
        check("err_hold",  32'(bus.err),        32'(ERR_EN));
        check("err_cnt3",  32'(bus.byte_count), 3);
        cyc(1'b1, 8'h66, 1'b0);
        cyc(1'b1, 8'h67, 1'b0);
        check("pre_rst_cnt", 32'(bus.byte_count), 5);
        pulse_reset();
        cyc(1'b1, 8'h71, 1'b0);
        cyc(1'b1, 8'h72, 1'b0);
        check("post_rst_word", 32'(bus.r_data),     32'h7172);
        check("post_rst_cnt",  32'(bus.byte_count), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
